// File: rtl/crossbar_nxn_reg.sv
// crossbar_nxn_reg: NxN crossbar with per-output round-robin arbitration and registered outputs.
// Define XBAR_FIXED_PRIO_EN to use fixed lowest-index priority instead of round-robin.
module crossbar_nxn_reg #(
  parameter  int WIDTH = 4,
  parameter  int PORTS = 4,
  localparam int SEL_W = $clog2(PORTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS*WIDTH-1:0] in_data,
  input  logic [PORTS-1:0]       in_valid,
  output logic [PORTS-1:0]       in_ready,
  input  logic                   cfg_we,
  input  logic [SEL_W-1:0]       cfg_port,
  input  logic [SEL_W-1:0]       cfg_dest,
  output logic [PORTS*WIDTH-1:0] out_data,
  output logic [PORTS-1:0]       out_valid,
  input  logic [PORTS-1:0]       out_ready
);

  localparam logic [SEL_W:0] PORTS_L = (SEL_W+1)'(PORTS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(PORTS-1);

  logic [SEL_W-1:0] dest     [PORTS];
  logic [PORTS-1:0] req      [PORTS];
  logic [SEL_W-1:0] gnt_idx  [PORTS];
  logic [WIDTH-1:0] load_data[PORTS];
  logic [PORTS-1:0] gnt_vld;
  logic [PORTS-1:0] can_load;
  logic             cfg_ok;

  assign cfg_ok = cfg_we
               && ({1'b0, cfg_port} < PORTS_L)
               && ({1'b0, cfg_dest} < PORTS_L);

  // destination table; identity after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PORTS; i++)
        dest[i] <= SEL_W'(i);
    end else if (cfg_ok) begin
      dest[cfg_port] <= cfg_dest;
    end
  end

  // request matrix: req[o][i] when input i targets output o
  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < PORTS; i++)
        req[o][i] = in_valid[i] && (dest[i] == SEL_W'(o));
    end
  end

  // an output may take a new word when empty or draining now
  assign can_load = ~out_valid | out_ready;

`ifdef XBAR_FIXED_PRIO_EN

  // fixed priority: lowest requesting index wins
  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = '0;
      for (int i = 0; i < PORTS; i++) begin
        if (!gnt_vld[o] && req[o][i]) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = SEL_W'(i);
        end
      end
    end
  end

`else

  logic [SEL_W-1:0] rr    [PORTS];
  logic [SEL_W-1:0] nxt_rr[PORTS];

  // round-robin: first requester at or after rr[o], wrapping
  always_comb begin
    int c;
    c = 0;
    for (int o = 0; o < PORTS; o++) begin
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = '0;
      for (int k = 0; k < PORTS; k++) begin
        c = int'(rr[o]) + k;
        if (c >= PORTS)
          c = c - PORTS;
        if (!gnt_vld[o] && req[o][c]) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = SEL_W'(c);
        end
      end
    end
  end

  // pointer moves just past the winner
  always_comb begin
    for (int o = 0; o < PORTS; o++)
      nxt_rr[o] = (gnt_idx[o] == LAST) ? '0 : gnt_idx[o] + 1'b1;
  end

  // pointer advances only when a grant actually loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < PORTS; o++)
        rr[o] <= '0;
    end else begin
      for (int o = 0; o < PORTS; o++)
        if (can_load[o] && gnt_vld[o])
          rr[o] <= nxt_rr[o];
    end
  end

`endif

  // handshake back to winners whose output can take the word
  always_comb begin
    in_ready = '0;
    for (int o = 0; o < PORTS; o++)
      if (gnt_vld[o] && can_load[o])
        in_ready[gnt_idx[o]] = 1'b1;
  end

  // steer the winning word to each output
  always_comb begin
    for (int o = 0; o < PORTS; o++)
      load_data[o] = in_data[int'(gnt_idx[o])*WIDTH +: WIDTH];
  end

  // one-deep output registers; hold under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= '0;
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        if (can_load[o]) begin
          if (gnt_vld[o]) begin
            out_data[o*WIDTH +: WIDTH] <= load_data[o];
            out_valid[o]               <= 1'b1;
          end else begin
            out_valid[o] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_crossbar_nxn_reg.sv
// tb_crossbar_nxn_reg: directed and random traffic against a
// reference model of the registered crossbar.
module tb_crossbar_nxn_reg;

  localparam int W = 4;
  localparam int P = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [P*W-1:0] in_data;
  logic [P-1:0]   in_valid;
  logic [P-1:0]   in_ready;
  logic           cfg_we;
  logic [1:0]     cfg_port;
  logic [1:0]     cfg_dest;
  logic [P*W-1:0] out_data;
  logic [P-1:0]   out_valid;
  logic [P-1:0]   out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state
  int         dm [P];
  int         rrm[P];
  int         win[P];
  logic [3:0] ovm;
  logic [3:0] odm[P];
  logic [3:0] canl;
  logic [3:0] erdy;

  crossbar_nxn_reg #(.WIDTH(W), .PORTS(P)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready),
    .cfg_we(cfg_we), .cfg_port(cfg_port),
    .cfg_dest(cfg_dest),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack();
    logic [15:0] r;
    for (int o = 0; o < P; o++)
      r[o*W +: W] = odm[o];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < P; i++) begin
      dm[i]  = i;
      rrm[i] = 0;
      odm[i] = '0;
    end
    ovm = '0;
  endtask

  // winner = requester closest (cyclically) after the pointer
  task automatic model_comb();
    int best, d;
    for (int o = 0; o < P; o++) begin
      win[o]  = -1;
      best    = P;
      canl[o] = !ovm[o] || out_ready[o];
      for (int i = 0; i < P; i++) begin
        if (in_valid[i] && dm[i] == o) begin
`ifdef XBAR_FIXED_PRIO_EN
          d = i;
`else
          d = (i - rrm[o] + P) % P;
`endif
          if (d < best) begin
            best   = d;
            win[o] = i;
          end
        end
      end
    end
    erdy = '0;
    for (int o = 0; o < P; o++)
      if (win[o] >= 0 && canl[o])
        erdy[win[o]] = 1'b1;
  endtask

  task automatic model_seq();
    for (int o = 0; o < P; o++) begin
      if (canl[o]) begin
        if (win[o] >= 0) begin
          odm[o] = in_data[win[o]*W +: W];
          ovm[o] = 1'b1;
          rrm[o] = (win[o] + 1) % P;
        end else begin
          ovm[o] = 1'b0;
        end
      end
    end
    if (cfg_we)
      dm[cfg_port] = int'(cfg_dest);
  endtask

  // inputs already applied; check at negedge, advance at posedge
  task automatic cycle();
    model_comb();
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(erdy));
    check("out_valid", 32'(out_valid), 32'(ovm));
    check("out_data", 32'(out_data), 32'(pack()));
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    cfg_we = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic cfg(input int p, input int d);
    cfg_we   = 1'b1;
    cfg_port = 2'(p);
    cfg_dest = 2'(d);
    cycle();
    cfg_we = 1'b0;
  endtask

  initial begin
    logic [3:0] held;
    logic [3:0] seq3 [6];
    seq3 = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1, 4'h2};

    in_data   = '0;
    in_valid  = '0;
    out_ready = '0;
    cfg_we    = 1'b0;
    cfg_port  = '0;
    cfg_dest  = '0;
    do_reset();

    // reset state
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);

    // 1: identity routing
    in_data   = 16'h4321;
    in_valid  = 4'hF;
    out_ready = 4'hF;
    cycle();
    check("t1_data", 32'(out_data), 32'h4321);
    check("t1_valid", 32'(out_valid), 32'hF);
    check("t1_ready", 32'(in_ready), 32'hF);
    cycle();

    // 2: pairwise swap programmed while traffic runs
    cfg(0, 1);
    check("t2_straight", 32'(out_data), 32'h4321);
    cfg(1, 0);
    cfg(2, 3);
    cfg(3, 2);
    cycle();
    check("t2_swap", 32'(out_data), 32'h3412);
    cycle();

    // 3: all inputs to output 2
    do_reset();
    cfg(0, 2);
    cfg(1, 2);
    cfg(3, 2);
    in_data   = 16'h4321;
    in_valid  = 4'hF;
    out_ready = 4'hF;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("t3_seq", 32'(out_data[11:8]), 32'(seq3[k]));
      check("t3_valid", 32'(out_valid), 32'h4);
    end

    // 4: backpressure on output 2
    out_ready = 4'b1011;
    held = out_data[11:8];
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t4_hold", 32'(out_data[11:8]), 32'(held));
      check("t4_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 4'hF;
    cycle();
    check("t4_release", 32'(out_data[11:8]), 32'h3);

    // 5: asynchronous reset between edges
    cycle();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_valid", 32'(out_valid), 32'h0);
    check("t5_data", 32'(out_data), 32'h0);
    model_reset();
    in_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_data   = 16'h4321;
    in_valid  = 4'hF;
    out_ready = 4'hF;
    cycle();
    check("t5_ident", 32'(out_data), 32'h4321);

    // 6: inputs 0 and 3 contend for output 1
    do_reset();
    cfg(0, 1);
    cfg(3, 1);
    in_data   = 16'h9005;
    in_valid  = 4'b1001;
    out_ready = 4'hF;
    for (int k = 0; k < 8; k++) begin
      cycle();
`ifdef XBAR_FIXED_PRIO_EN
      check("t6_starve", 32'(in_ready[3]), 32'h0);
`endif
    end

    // random traffic and reprogramming
    do_reset();
    for (int k = 0; k < 400; k++) begin
      in_data   = 16'($urandom);
      in_valid  = 4'($urandom);
      out_ready = 4'($urandom);
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_port  = 2'($urandom);
      cfg_dest  = 2'($urandom);
      cycle();
    end
    cfg_we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
